// File: rtl/riscv_alu.sv
// riscv_alu: 32-bit integer ALU for the execute stage.
// Produces a combinational result plus a registered copy and a registered zero flag.
// Build option: define ALU_SHAMT5_EN to use only srcb[4:0] as the shift amount.
// The default build uses the full 32-bit srcb as the shift amount.
module riscv_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [5:0]  aluCtrl,
  output logic [31:0] aluOut,
  output logic [31:0] aluOutQ,
  output logic        zeroQ
);

  localparam logic [31:0] BranchTaken = 32'h8000_0000;
  localparam logic [31:0] BadOp       = 32'hDEAD_BEAF;

  logic [31:0] shamt;
  logic        shamt_big;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic        eq;
  logic        lt_s;
  logic        lt_u;

  // Shift amount selection and shifter datapath
  always_comb begin
`ifdef ALU_SHAMT5_EN
    shamt = {27'd0, srcb[4:0]};
`else
    shamt = srcb;
`endif
    // Any amount past 31 empties the word (or fills it with the sign for sra)
    shamt_big = (shamt > 32'd31);
    sll_res   = shamt_big ? 32'd0 : (srca << shamt[4:0]);
    srl_res   = shamt_big ? 32'd0 : (srca >> shamt[4:0]);
    sra_res   = shamt_big ? {32{srca[31]}} : 32'($signed(srca) >>> shamt[4:0]);
  end

  // Comparators shared by set-less-than and branch compares
  always_comb begin
    eq   = (srca == srcb);
    lt_s = ($signed(srca) < $signed(srcb));
    lt_u = (srca < srcb);
  end

  // Result mux; branch compares report only via bit 31
  always_comb begin
    aluOut = BadOp;
    unique case (aluCtrl)
      6'd0:    aluOut = srca + srcb;
      6'd1:    aluOut = srca - srcb;
      6'd2:    aluOut = srca ^ srcb;
      6'd3:    aluOut = sll_res;
      6'd4:    aluOut = srl_res;
      6'd5:    aluOut = sra_res;
      6'd6:    aluOut = srca & srcb;
      6'd7:    aluOut = srca | srcb;
      6'd8:    aluOut = {31'd0, lt_s};
      6'd9:    aluOut = eq    ? BranchTaken : 32'd0;
      6'd10:   aluOut = !eq   ? BranchTaken : 32'd0;
      6'd11:   aluOut = lt_s  ? BranchTaken : 32'd0;
      6'd12:   aluOut = !lt_s ? BranchTaken : 32'd0;
      6'd13:   aluOut = {31'd0, lt_u};
      6'd14:   aluOut = lt_u  ? BranchTaken : 32'd0;
      6'd15:   aluOut = !lt_u ? BranchTaken : 32'd0;
      default: aluOut = BadOp;
    endcase
  end

  // Pipeline copy of the result; reset value reads as a zero result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluOutQ <= 32'd0;
      zeroQ   <= 1'b1;
    end else begin
      aluOutQ <= aluOut;
      zeroQ   <= (aluOut == 32'd0);
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: directed and randomized checks of riscv_alu against an arithmetic model.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [5:0]  aluCtrl;
  logic [31:0] aluOut;
  logic [31:0] aluOutQ;
  logic        zeroQ;

  int nvec = 0;
  int nerr = 0;

  riscv_alu dut (
    .clk     (clk),
    .rst     (rst),
    .srca    (srca),
    .srcb    (srcb),
    .aluCtrl (aluCtrl),
    .aluOut  (aluOut),
    .aluOutQ (aluOutQ),
    .zeroQ   (zeroQ)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 64-bit values
  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [5:0] op);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned m  = 64'd1 << 32;
    longint unsigned amt;
    longint          p;
`ifdef ALU_SHAMT5_EN
    amt = ub % 32;
`else
    amt = ub;
`endif
    p = (amt < 32) ? (longint'(1) << amt) : 0;
    case (op)
      6'd0:  return 32'((ua + ub) % m);
      6'd1:  return 32'((ua + m - ub) % m);
      6'd2:  return a ^ b;
      6'd3:  return (amt >= 32) ? 32'd0 : 32'((ua * longint'(p)) % m);
      6'd4:  return (amt >= 32) ? 32'd0 : 32'(ua / longint'(p));
      6'd5: begin
        if (amt >= 32) return (sa < 0) ? 32'hFFFF_FFFF : 32'd0;
        // floor division of a signed value by 2^amt
        if (sa < 0) return 32'((sa - (p - 1)) / p);
        return 32'(sa / p);
      end
      6'd6:  return a & b;
      6'd7:  return a | b;
      6'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      6'd9:  return (ua == ub) ? 32'h8000_0000 : 32'd0;
      6'd10: return (ua != ub) ? 32'h8000_0000 : 32'd0;
      6'd11: return (sa < sb) ? 32'h8000_0000 : 32'd0;
      6'd12: return (sa >= sb) ? 32'h8000_0000 : 32'd0;
      6'd13: return (ua < ub) ? 32'd1 : 32'd0;
      6'd14: return (ua < ub) ? 32'h8000_0000 : 32'd0;
      6'd15: return (ua >= ub) ? 32'h8000_0000 : 32'd0;
      default: return 32'hDEAD_BEAF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply operands, then check the combinational result against a constant
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                       input logic [31:0] exp, input string tag);
    srca = a; srcb = b; aluCtrl = op;
    #1;
    chk(tag, aluOut, exp);
  endtask

  logic [31:0] ra, rb, rexp;
  logic [5:0]  rop;
  logic [31:0] t15 [16];
  logic [31:0] t8 [8];

  initial begin
    t15 = '{32'd31, 32'd11, 32'd31, 32'h5400, 32'd0, 32'd0, 32'd0, 32'd31,
            32'd0, 32'd0, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000};
    t8  = '{32'd1, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'h8000_0000};

    rst = 1'b1; srca = 32'd5; srcb = 32'd7; aluCtrl = 6'd0;
    #2;
    chk("reset_q", aluOutQ, 32'd0);
    chk("reset_zero", {31'd0, zeroQ}, 32'd1);
    chk("reset_comb", aluOut, 32'd12);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(32'd21, 32'd10, 6'(i), t15[i], $sformatf("sweep_op%0d", i));
    for (int i = 0; i < 8; i++)
      apply(32'h8000_0000, 32'd1, 6'(i + 8), t8[i], $sformatf("min_op%0d", i + 8));

    apply(32'hF000_0000, 32'd4, 6'd5, 32'hFF00_0000, "sra4");
    apply(32'hF000_0000, 32'd4, 6'd4, 32'h0F00_0000, "srl4");
`ifdef ALU_SHAMT5_EN
    apply(32'hF000_0000, 32'd40, 6'd4, 32'h00F0_0000, "srl40");
    apply(32'hF000_0000, 32'd40, 6'd5, 32'hFFF0_0000, "sra40");
    apply(32'd3, 32'd33, 6'd3, 32'd6, "sll33");
`else
    apply(32'hF000_0000, 32'd40, 6'd5, 32'hFFFF_FFFF, "sra40");
    apply(32'hF000_0000, 32'd40, 6'd4, 32'd0, "srl40");
    apply(32'd3, 32'd33, 6'd3, 32'd0, "sll33");
`endif
    apply(32'h1234_5678, 32'h9ABC_DEF0, 6'd16, 32'hDEAD_BEAF, "op16");
    apply(32'h0, 32'hFFFF_FFFF, 6'd63, 32'hDEAD_BEAF, "op63");
    apply(32'hFFFF_FFFF, 32'd1, 6'd0, 32'd0, "wrap_add");

    // Register path: load a non-zero value, then reset mid-cycle
    @(negedge clk);
    apply(32'd3, 32'd3, 6'd0, 32'd6, "pre_add");
    @(posedge clk); #1;
    chk("pre_q", aluOutQ, 32'd6);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", aluOutQ, 32'd0);
    chk("async_rst_zero", {31'd0, zeroQ}, 32'd1);
    chk("rst_comb", aluOut, 32'd6);
    @(negedge clk);
    rst = 1'b0;
    apply(32'd3, 32'd3, 6'd1, 32'd0, "sub_comb");
    @(posedge clk); #1;
    chk("sub_q", aluOutQ, 32'd0);
    chk("sub_zero", {31'd0, zeroQ}, 32'd1);
    @(negedge clk);
    apply(32'd3, 32'd3, 6'd0, 32'd6, "add_comb");
    @(posedge clk); #1;
    chk("add_q", aluOutQ, 32'd6);
    chk("add_zero", {31'd0, zeroQ}, 32'd0);

    // Randomized vectors against the model, combinational and registered
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ra  = $urandom;
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 70));
        1:       rb = ra;
        2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      rexp = ref_alu(ra, rb, rop);
      srca = ra; srcb = rb; aluCtrl = rop;
      #1;
      chk($sformatf("rand_comb op%0d a=%h b=%h", rop, ra, rb), aluOut, rexp);
      @(posedge clk); #1;
      chk($sformatf("rand_q op%0d", rop), aluOutQ, rexp);
      chk($sformatf("rand_zero op%0d", rop), {31'd0, zeroQ}, {31'd0, rexp == 32'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
